cmp_serial: RTL

CMP_SERIAL -- requirements
Module: cmp_serial

---
 rtl/cmp_serial_pkg.sv | 37 +++
 rtl/cmp_serial_if.sv | 28 ++
 rtl/cmp_serial_digit.sv | 14 +
 rtl/cmp_serial.sv | 125 ++++++++++++
 4 files changed

// File: rtl/cmp_serial_pkg.sv
// Shared types for the serial comparator: op codes, FSM states and the
// predicate selection helper.
package cmp_pkg;

  typedef enum logic [2:0] {
    OP_GT   = 3'd0,
    OP_LT   = 3'd1,
    OP_EQ   = 3'd2,
    OP_NE   = 3'd3,
    OP_GE   = 3'd4,
    OP_LE   = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  // Reduce the one-hot relation to the single predicate bit for an op.
  function automatic logic cmp_pred(cmp_op_e op, logic gt, logic lt, logic eq);
    logic p;
    case (op)
      OP_GT:   p = gt;
      OP_LT:   p = lt;
      OP_EQ:   p = eq;
      OP_NE:   p = ~eq;
      OP_GE:   p = gt | eq;
      OP_LE:   p = lt | eq;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cmp_serial_if.sv
// Request/response bundle of the serial comparator.
interface cmp_serial_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             gt;
  logic             lt;
  logic             eq;
  logic             busy;

  modport master (
    output in_valid, a, b, op, is_signed, out_ready,
    input  in_ready, out_valid, c, gt, lt, eq, busy
  );

  modport slave (
    input  in_valid, a, b, op, is_signed, out_ready,
    output in_ready, out_valid, c, gt, lt, eq, busy
  );
endinterface

// File: rtl/cmp_serial_digit.sv
// Combinational unsigned compare of one DIGIT-wide slice.
module cmp_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             gt_o,
  output logic             lt_o,
  output logic             eq_o
);
  assign gt_o = (a_i > b_i);
  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);
endmodule

// File: rtl/cmp_serial.sv
// Serial magnitude comparator: scans operands MSB-first, one digit per
// cycle, stopping at the first differing digit.
module cmp_serial
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  cmp_serial_if.slave  bus
);
  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [KW-1:0]    K_LAST   = KW'(N - 1);

  cmp_state_e       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  cmp_op_e          op_q, op_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d, pred_q, pred_d;

  logic d_gt, d_lt, d_eq;

  // Operands are shifted left each SCAN step, so the digit under test
  // (digit k) always sits in the top DIGIT bits.
  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i  (a_q[WIDTH-1 -: DIGIT]),
    .b_i  (b_q[WIDTH-1 -: DIGIT]),
    .gt_o (d_gt),
    .lt_o (d_lt),
    .eq_o (d_eq)
  );

  // State, pointer, operand and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_GT;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      pred_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      pred_q  <= pred_d;
    end
  end

  // Next-state: accept in IDLE, digit scan in SCAN, hold until taken in DONE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    pred_d  = pred_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = SCAN;
          k_d     = '0;
          // Flipping the sign bit maps two's complement onto offset binary,
          // so the scan itself is always unsigned.
          a_d     = bus.is_signed ? (bus.a ^ MSB_MASK) : bus.a;
          b_d     = bus.is_signed ? (bus.b ^ MSB_MASK) : bus.b;
          op_d    = cmp_op_e'(bus.op);
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          pred_d  = 1'b0;
        end
      end
      SCAN: begin
        if (!d_eq) begin
          gt_d    = d_gt;
          lt_d    = d_lt;
          pred_d  = cmp_pred(op_q, d_gt, d_lt, 1'b0);
          state_d = DONE;
        end else if (k_q == K_LAST) begin
          eq_d    = 1'b1;
          pred_d  = cmp_pred(op_q, 1'b0, 1'b0, 1'b1);
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
          a_d = a_q << DIGIT;
          b_d = b_q << DIGIT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          pred_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == SCAN) || (state_q == DONE);
  assign bus.c         = {{(WIDTH-1){1'b0}}, pred_q & bus.out_valid};
  assign bus.gt        = gt_q & bus.out_valid;
  assign bus.lt        = lt_q & bus.out_valid;
  assign bus.eq        = eq_q & bus.out_valid;

endmodule
